// File: rtl/fifo_sync_flex.sv
// Single-clock FIFO with optional first-word-fall-through output, programmable
// level flags, occupancy count and registered overflow/underflow pulses.
module fifo_sync_flex #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 32,
    parameter int PROG_FULL  = DEPTH / 2,
    parameter int PROG_EMPTY = 1,
    parameter int FWFT       = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           din,
    input  logic                       wr_en,
    output logic                       full,
    output logic                       prog_full,
    output logic [WIDTH-1:0]           dout,
    input  logic                       rd_en,
    output logic                       empty,
    output logic                       prog_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
    localparam logic [CW-1:0] PF_LVL    = CW'(PROG_FULL);
    localparam logic [CW-1:0] PE_LVL    = CW'(PROG_EMPTY);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("fifo_sync_flex: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    ram_cnt;
    logic [WIDTH-1:0] dout_q;
    logic             dout_valid;
    logic             ovf_q;
    logic             unf_q;
    logic             empty_i;
    logic             do_wr;
    logic             do_rd;
    logic             fetch;

    // In FWFT mode count covers the word parked in dout; ram_cnt is what is
    // still waiting in the array.
    assign ram_cnt = count_q - {{PW{1'b0}}, dout_valid};
    assign empty_i = (FWFT != 0) ? ~dout_valid : (count_q == '0);
    assign full    = (count_q == FULL_LVL);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty_i;
    // Refill the output register whenever it is empty or being popped.
    assign fetch   = (FWFT != 0) ? ((ram_cnt != '0) && (!dout_valid || do_rd)) : do_rd;

    assign empty      = empty_i;
    assign prog_full  = (count_q >= PF_LVL);
    assign prog_empty = (count_q <= PE_LVL);
    assign count      = count_q;
    assign dout       = dout_q;
    assign overflow   = ovf_q;
    assign underflow  = unf_q;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            dout_q     <= '0;
            dout_valid <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (fetch) begin
                dout_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PW'(1);
            end
            dout_valid <= (FWFT != 0) && (fetch || (dout_valid && !do_rd));
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            ovf_q <= wr_en & full;
            unf_q <= rd_en & empty_i;
        end
    end
endmodule

// File: tb/tb_fifo_sync_flex.sv
// Bench for fifo_sync_flex: a standard-mode DEPTH=4 FIFO and an FWFT DEPTH=8
// FIFO share one stimulus stream and are checked every cycle against queue models.
module tb_fifo_sync_flex;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       wr_en, rd_en;

    logic       full_a, pfull_a, empty_a, pempty_a, ovf_a, unf_a;
    logic [7:0] dout_a;
    logic [2:0] cnt_a;
    logic       full_b, pfull_b, empty_b, pempty_b, ovf_b, unf_b;
    logic [7:0] dout_b;
    logic [3:0] cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_sync_flex #(.WIDTH(8), .DEPTH(4), .FWFT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .full(full_a),
        .prog_full(pfull_a), .dout(dout_a), .rd_en(rd_en), .empty(empty_a),
        .prog_empty(pempty_a), .count(cnt_a), .overflow(ovf_a), .underflow(unf_a));

    fifo_sync_flex #(.WIDTH(8), .DEPTH(8), .PROG_FULL(6), .PROG_EMPTY(1), .FWFT(1)) u_b (
        .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .full(full_b),
        .prog_full(pfull_b), .dout(dout_b), .rd_en(rd_en), .empty(empty_b),
        .prog_empty(pempty_b), .count(cnt_b), .overflow(ovf_b), .underflow(unf_b));

    // Models: contents as queues; FWFT head is visible once at least one full
    // edge has passed since it was written.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int         tb_t[$];
    logic [7:0] da;
    bit         ova, una, ovb, unb;
    int         edge_n = 0;

    function automatic bit b_emp();
        return !(qb.size() > 0 && tb_t[0] < edge_n);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        qa.delete(); qb.delete(); tb_t.delete();
        da = 8'h00; ova = 0; una = 0; ovb = 0; unb = 0;
    endtask

    task automatic model_edge(input bit w, input bit r, input logic [7:0] d);
        bit a_full, a_emp, b_full, b_e;
        a_full = (qa.size() == 4);
        a_emp  = (qa.size() == 0);
        b_full = (qb.size() == 8);
        b_e    = b_emp();
        ova = w && a_full;  una = r && a_emp;
        ovb = w && b_full;  unb = r && b_e;
        if (r && !a_emp) da = qa.pop_front();
        if (w && !a_full) qa.push_back(d);
        if (r && !b_e) begin
            void'(qb.pop_front());
            void'(tb_t.pop_front());
        end
        edge_n++;
        if (w && !b_full) begin
            qb.push_back(d);
            tb_t.push_back(edge_n);
        end
    endtask

    task automatic check_all();
        chk("a_count", 32'(cnt_a), 32'(qa.size()));
        chk("a_empty", 32'(empty_a), 32'(qa.size() == 0));
        chk("a_full", 32'(full_a), 32'(qa.size() == 4));
        chk("a_prog_full", 32'(pfull_a), 32'(qa.size() >= 2));
        chk("a_prog_empty", 32'(pempty_a), 32'(qa.size() <= 1));
        chk("a_dout", 32'(dout_a), 32'(da));
        chk("a_overflow", 32'(ovf_a), 32'(ova));
        chk("a_underflow", 32'(unf_a), 32'(una));
        chk("b_count", 32'(cnt_b), 32'(qb.size()));
        chk("b_empty", 32'(empty_b), 32'(b_emp()));
        chk("b_full", 32'(full_b), 32'(qb.size() == 8));
        chk("b_prog_full", 32'(pfull_b), 32'(qb.size() >= 6));
        chk("b_prog_empty", 32'(pempty_b), 32'(qb.size() <= 1));
        if (!b_emp()) chk("b_dout", 32'(dout_b), 32'(qb[0]));
        chk("b_overflow", 32'(ovf_b), 32'(ovb));
        chk("b_underflow", 32'(unf_b), 32'(unb));
    endtask

    task automatic step(input bit w, input bit r, input logic [7:0] d);
        wr_en = w; rd_en = r; din = d;
        @(posedge clk);
        model_edge(w, r, d);
        #1 check_all();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        model_reset();
        #1 check_all();
        chk("rst_count_a", 32'(cnt_a), 0);
        chk("rst_empty_b", 32'(empty_b), 1);
        chk("rst_dout_a", 32'(dout_a), 0);
        chk("rst_dout_b", 32'(dout_b), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        int pw, pr;
        rst_n = 1'b0; wr_en = 0; rd_en = 0; din = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_all();
        chk("init_pfull_b", 32'(pfull_b), 0);
        chk("init_pempty_a", 32'(pempty_a), 1);

        // fill standard-mode FIFO, overflow, drain in order
        step(1, 0, 8'h11); step(1, 0, 8'h22); step(1, 0, 8'h33); step(1, 0, 8'h44);
        chk("t2_full_a", 32'(full_a), 1);
        chk("t2_count_a", 32'(cnt_a), 4);
        step(1, 0, 8'h55);
        chk("t2_overflow_a", 32'(ovf_a), 1);
        chk("t2_count_hold_a", 32'(cnt_a), 4);
        step(0, 0, 8'h00);
        chk("t2_overflow_clear_a", 32'(ovf_a), 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 8'h00);
            chk("t2_read_a", 32'(dout_a), 32'(8'h11 * (k + 1)));
        end
        step(0, 1, 8'h00);
        step(0, 0, 8'h00);

        // FWFT bubble and pop-with-prefetch
        step(1, 0, 8'hA5);
        chk("t4_bubble_empty_b", 32'(empty_b), 1);
        step(0, 0, 8'h00);
        chk("t4_empty_b", 32'(empty_b), 0);
        chk("t4_dout_b", 32'(dout_b), 32'h A5);
        step(1, 0, 8'h5A);
        step(0, 1, 8'h00);
        chk("t4_next_dout_b", 32'(dout_b), 32'h5A);
        chk("t4_next_empty_b", 32'(empty_b), 0);
        step(0, 1, 8'h00);

        // programmable levels on the DEPTH=8 FIFO
        for (int k = 1; k <= 7; k++) begin
            step(1, 0, 8'(8'h60 + k));
            chk("t5_prog_full_b", 32'(pfull_b), 32'(k >= 6));
            chk("t5_prog_empty_b", 32'(pempty_b), 32'(k <= 1));
        end
        for (int k = 0; k < 7; k++) step(0, 1, 8'h00);
        step(0, 1, 8'h00);
        chk("t5_underflow_b", 32'(unf_b), 1);
        chk("t5_count_b", 32'(cnt_b), 0);

        // steady simultaneous access with wrap at count 2
        step(1, 0, 8'h80); step(1, 0, 8'h81);
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 8'(8'h82 + i));
            chk("t3_count_a", 32'(cnt_a), 2);
            chk("t3_dout_a", 32'(dout_a), 32'(8'h80 + i));
            chk("t3_no_err_a", 32'({ovf_a, unf_a}), 0);
        end
        step(0, 1, 8'h00); step(0, 1, 8'h00); step(0, 0, 8'h00);

        // mid-stream reset then clean reuse
        for (int i = 0; i < 10; i++) step(1'($urandom), 1'($urandom), 8'($urandom));
        pulse_reset();
        for (int k = 0; k < 4; k++) step(1, 0, 8'(8'hC1 + k));
        step(0, 0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 8'h00);
            chk("t1_read_a", 32'(dout_a), 32'(8'hC1 + k));
        end

        // random traffic in phases of differing write/read pressure
        for (int i = 0; i < 10000; i++) begin
            case ((i / 500) % 4)
                0: begin pw = 80; pr = 20; end
                1: begin pw = 20; pr = 80; end
                2: begin pw = 50; pr = 50; end
                default: begin pw = 95; pr = 95; end
            endcase
            step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
